// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: turns a stream of 32-bit big-endian message words into
// SHA-256 padded 512-bit blocks, emitted as 16-word groups through a single
// registered output stage.
// Optional feature macro: MSG_PAD_OVF_EN (message length limit of MAX_WORDS
// with a sticky overflow flag).
module sha256_msg_padder #(
  parameter int unsigned MAX_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_first,
  output logic        out_last_blk,
  output logic        busy,
  output logic        ovf
);

  localparam logic [2:0] S_DATA  = 3'd0;
  localparam logic [2:0] S_PAD   = 3'd1;
  localparam logic [2:0] S_ZERO  = 3'd2;
  localparam logic [2:0] S_LENHI = 3'd3;
  localparam logic [2:0] S_LENLO = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_cnt;
  logic [3:0]  r_pos;
  logic        r_valid;
  logic [31:0] r_data;
  logic        r_first;
  logic        r_last;

  logic        w_load;
  logic        w_accept;
  logic        w_drop;
  logic [3:0]  w_pos_nxt;

  assign w_load    = !r_valid || out_ready;
  assign w_accept  = (r_state == S_DATA) && in_valid && w_load;
  assign w_pos_nxt = r_pos + 4'd1;

  assign in_ready     = (r_state == S_DATA) && w_load;
  assign out_valid    = r_valid;
  assign out_data     = r_data;
  assign out_first    = r_first;
  assign out_last_blk = r_last;
  assign busy         = (r_state != S_DATA) || (r_cnt != '0);

`ifdef MSG_PAD_OVF_EN
  logic r_ovf;

  assign w_drop = w_accept && (r_cnt == MAX_WORDS);
  assign ovf    = r_ovf;

  // Sticky overflow: set on a dropped word, cleared by the next message's first word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (r_cnt == '0) begin
        r_ovf <= 1'b0;
      end
    end
  end
`else
  assign w_drop = 1'b0;
  assign ovf    = 1'b0;
`endif

  // Padding FSM and output register; everything advances only when the output register loads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_DATA;
      r_cnt   <= '0;
      r_pos   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b0;
      case (r_state)
        S_DATA: begin
          if (in_valid) begin
            if (!w_drop) begin
              r_valid <= 1'b1;
              r_data  <= in_data;
              r_first <= (r_pos == 4'd0);
              r_last  <= 1'b0;
              r_pos   <= w_pos_nxt;
              r_cnt   <= r_cnt + 32'd1;
            end
            if (in_last) begin
              r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          r_valid <= 1'b1;
          r_data  <= 32'h8000_0000;
          r_first <= (r_pos == 4'd0);
          r_last  <= 1'b0;
          r_pos   <= w_pos_nxt;
          r_state <= (w_pos_nxt == 4'd14) ? S_LENHI : S_ZERO;
        end
        S_ZERO: begin
          r_valid <= 1'b1;
          r_data  <= '0;
          r_first <= (r_pos == 4'd0);
          r_last  <= 1'b0;
          r_pos   <= w_pos_nxt;
          if (w_pos_nxt == 4'd14) begin
            r_state <= S_LENHI;
          end
        end
        S_LENHI: begin
          r_valid <= 1'b1;
          r_data  <= {27'b0, r_cnt[31:27]};
          r_first <= 1'b0;
          r_last  <= 1'b0;
          r_pos   <= w_pos_nxt;
          r_state <= S_LENLO;
        end
        S_LENLO: begin
          r_valid <= 1'b1;
          r_data  <= {r_cnt[26:0], 5'b0};
          r_first <= 1'b0;
          r_last  <= 1'b1;
          r_pos   <= '0;
          r_cnt   <= '0;
          r_state <= S_DATA;
        end
        default: begin
          r_state <= S_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed testbench for sha256_msg_padder. Inputs change 2ns after the
// rising edge; outputs and handshakes are observed on the falling edge.
// Build with MSG_PAD_OVF_EN defined to include the overflow scenario.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last_blk;
  logic        busy;
  logic        ovf;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
  } ow_t;

  ow_t q[$];
  ow_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  stall_cnt = 0;
  bit  rand_ready = 1'b0;

  logic [31:0] st_d;
  logic        st_f;
  logic        st_l;
  bit          st_pend = 1'b0;

  always #5 clk = ~clk;

  sha256_msg_padder #(.MAX_WORDS(20)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_first   (out_first),
    .out_last_blk(out_last_blk),
    .busy        (busy),
    .ovf         (ovf)
  );

  // Downstream ready: always high, or a coin flip per cycle when rand_ready is set
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output collector plus hold-stable check across stalled cycles
  always @(negedge clk) begin
    if (reset_n === 1'b1 && st_pend) begin
      checks++;
      if (out_data !== st_d || out_first !== st_f || out_last_blk !== st_l) begin
        errors++;
        $display("FAIL stall_hold: got %h/%b/%b required %h/%b/%b",
                 out_data, out_first, out_last_blk, st_d, st_f, st_l);
      end
    end
    st_pend = (reset_n === 1'b1) && out_valid && !out_ready;
    if (st_pend) stall_cnt++;
    st_d = out_data;
    st_f = out_first;
    st_l = out_last_blk;
    if (reset_n === 1'b1 && out_valid && out_ready)
      q.push_back('{out_data, out_first, out_last_blk});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mw(input logic [7:0] tag, input int i);
    return {tag, 8'h5A, 16'(i)};
  endfunction

  // Expected padded stream for n_fwd forwarded words tagged with tag
  function automatic void build_exp(input logic [7:0] tag, input int n_fwd);
    int          total;
    logic [31:0] cnt;
    ow_t         w;
    total = 16 * ((n_fwd + 3 + 15) / 16);
    cnt   = 32'(n_fwd);
    exp_q.delete();
    for (int p = 0; p < total; p++) begin
      if (p < n_fwd)           w.d = mw(tag, p);
      else if (p == n_fwd)     w.d = 32'h8000_0000;
      else if (p == total - 2) w.d = {27'b0, cnt[31:27]};
      else if (p == total - 1) w.d = {cnt[26:0], 5'b0};
      else                     w.d = 32'h0;
      w.f = (p % 16 == 0);
      w.l = (p == total - 1);
      exp_q.push_back(w);
    end
  endfunction

  // Drive one message; cyc returns the number of cycles taken to hand it over
  task automatic drive_msg(input logic [7:0] tag, input int n, input bit last_flag,
                           output int cyc);
    bit acc;
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = mw(tag, i);
      in_last  = last_flag && (i == n - 1);
      acc      = 1'b0;
      while (!acc && cyc <= 1000) begin
        @(negedge clk);
        acc = in_ready;
        cyc++;
        @(posedge clk);
        #2;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_q(input int n);
    int k = 0;
    while (q.size() < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h required 00000000", out_data); end
    checks++; if (out_first !== 1'b0) begin errors++; $display("FAIL rst_out_first: got %b required 0", out_first); end
    checks++; if (out_last_blk !== 1'b0) begin errors++; $display("FAIL rst_out_last_blk: got %b required 0", out_last_blk); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b required 0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #2;
  endtask

  task automatic test_msg20();
    int cyc;
    ow_t g;
    q.delete();
    build_exp(8'h20, 20);
    drive_msg(8'h20, 20, 1'b1, cyc);
    checks++; if (cyc !== 20) begin errors++; $display("FAIL msg20_in_cycles: got %0d required 20", cyc); end
    repeat (13) @(negedge clk);
    #1;
    checks++; if (q.size() !== 32) begin errors++; $display("FAIL msg20_count_at_full_rate: got %0d required 32", q.size()); end
    for (int p = 0; p < 32; p++) begin
      g = (p < q.size()) ? q[p] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL msg20_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
    if (q.size() == 32) begin
      checks++; if (q[20].d !== 32'h8000_0000) begin errors++; $display("FAIL msg20_pad: got %h required 80000000", q[20].d); end
      checks++; if (q[31].d !== 32'h0000_0280 || q[31].l !== 1'b1) begin errors++; $display("FAIL msg20_len: got %h/%b required 00000280/1", q[31].d, q[31].l); end
      checks++; if (q[16].f !== 1'b1) begin errors++; $display("FAIL msg20_first16: got %b required 1", q[16].f); end
    end
    @(posedge clk); #2;
  endtask

  task automatic test_msg13();
    int cyc;
    ow_t g;
    q.delete();
    build_exp(8'h13, 13);
    drive_msg(8'h13, 13, 1'b1, cyc);
    checks++; if (cyc !== 13) begin errors++; $display("FAIL msg13_in_cycles: got %0d required 13", cyc); end
    wait_q(16);
    checks++; if (q.size() !== 16) begin errors++; $display("FAIL msg13_count: got %0d required 16", q.size()); end
    for (int p = 0; p < 16; p++) begin
      g = (p < q.size()) ? q[p] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL msg13_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
    if (q.size() == 16) begin
      checks++; if (q[13].d !== 32'h8000_0000) begin errors++; $display("FAIL msg13_pad: got %h required 80000000", q[13].d); end
      checks++; if (q[15].d !== 32'h0000_01A0) begin errors++; $display("FAIL msg13_len: got %h required 000001A0", q[15].d); end
    end
  endtask

  task automatic test_msg14();
    int cyc;
    ow_t g;
    q.delete();
    build_exp(8'h14, 14);
    drive_msg(8'h14, 14, 1'b1, cyc);
    wait_q(32);
    checks++; if (q.size() !== 32) begin errors++; $display("FAIL msg14_count: got %0d required 32", q.size()); end
    for (int p = 0; p < 32; p++) begin
      g = (p < q.size()) ? q[p] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL msg14_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
    if (q.size() == 32) begin
      checks++; if (q[14].d !== 32'h8000_0000) begin errors++; $display("FAIL msg14_pad: got %h required 80000000", q[14].d); end
      checks++; if (q[15].l !== 1'b0 || q[15].d !== 32'h0) begin errors++; $display("FAIL msg14_pos15: got %h/%b required 00000000/0", q[15].d, q[15].l); end
      checks++; if (q[31].d !== 32'h0000_01C0) begin errors++; $display("FAIL msg14_len: got %h required 000001C0", q[31].d); end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    ow_t g;
    q.delete();
    stall_cnt  = 0;
    build_exp(8'h20, 20);
    rand_ready = 1'b1;
    drive_msg(8'h20, 20, 1'b1, cyc);
    wait_q(32);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL bp_stalls_seen: got %0d required >0", stall_cnt); end
    checks++; if (q.size() !== 32) begin errors++; $display("FAIL bp_count: got %0d required 32", q.size()); end
    for (int p = 0; p < 32; p++) begin
      g = (p < q.size()) ? q[p] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL bp_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  cyc1, cyc2;
    ow_t g;
    q.delete();
    drive_msg(8'h05, 5, 1'b1, cyc1);
    drive_msg(8'h03, 3, 1'b1, cyc2);
    checks++; if (cyc2 !== 14) begin errors++; $display("FAIL b2b_gapless_cycles: got %0d required 14", cyc2); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_padding: got %b required 1", busy); end
    wait_q(32);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_idle: got %b required 0", busy); end
    checks++; if (q.size() !== 32) begin errors++; $display("FAIL b2b_count: got %0d required 32", q.size()); end
    build_exp(8'h05, 5);
    for (int p = 0; p < 16; p++) begin
      g = (p < q.size()) ? q[p] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL b2b_m1_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
    build_exp(8'h03, 3);
    for (int p = 0; p < 16; p++) begin
      g = (p + 16 < q.size()) ? q[p + 16] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL b2b_m2_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
    if (q.size() == 32) begin
      checks++; if (q[15].d !== 32'h0000_00A0) begin errors++; $display("FAIL b2b_len1: got %h required 000000A0", q[15].d); end
      checks++; if (q[31].d !== 32'h0000_0060) begin errors++; $display("FAIL b2b_len2: got %h required 00000060", q[31].d); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    drive_msg(8'h77, 2, 1'b0, cyc);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b required 1", busy); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", busy); end
    @(posedge clk); #2;
    reset_n = 1'b1;
    q.delete();
    drive_msg(8'h01, 1, 1'b1, cyc);
    wait_q(16);
    checks++; if (q.size() !== 16) begin errors++; $display("FAIL rmid_count: got %0d required 16", q.size()); end
    if (q.size() == 16) begin
      checks++; if (q[0].d !== 32'h015A_0000 || q[0].f !== 1'b1) begin errors++; $display("FAIL rmid_word0: got %h/%b required 015A0000/1", q[0].d, q[0].f); end
      checks++; if (q[1].d !== 32'h8000_0000) begin errors++; $display("FAIL rmid_pad: got %h required 80000000", q[1].d); end
      checks++; if (q[15].d !== 32'h0000_0020 || q[15].l !== 1'b1) begin errors++; $display("FAIL rmid_len: got %h/%b required 00000020/1", q[15].d, q[15].l); end
    end
  endtask

`ifdef MSG_PAD_OVF_EN
  task automatic test_overflow();
    int  cyc;
    ow_t g;
    q.delete();
    build_exp(8'h16, 20);
    drive_msg(8'h16, 22, 1'b1, cyc);
    wait_q(32);
    checks++; if (q.size() !== 32) begin errors++; $display("FAIL ovf_count: got %0d required 32", q.size()); end
    for (int p = 0; p < 32; p++) begin
      g = (p < q.size()) ? q[p] : '0;
      checks++;
      if (g !== exp_q[p]) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h/%b/%b required %h/%b/%b", p, g.d, g.f, g.l, exp_q[p].d, exp_q[p].f, exp_q[p].l);
      end
    end
    if (q.size() == 32) begin
      checks++; if (q[31].d !== 32'h0000_0280) begin errors++; $display("FAIL ovf_len: got %h required 00000280", q[31].d); end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
    q.delete();
    drive_msg(8'h02, 1, 1'b1, cyc);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", ovf); end
    wait_q(16);
  endtask
`endif

  initial begin
    test_reset();
    test_msg20();
    test_msg13();
    test_msg14();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef MSG_PAD_OVF_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Upstream feeder for the SHA-256 hash core. It accepts a message as a stream of 32-bit big-endian words and emits SHA-256 padded 512-bit blocks as a stream of 16-word groups. Padding is a `32'h80000000` word, then zero words, then a 64-bit message length in bits. The hash core consumes the output one word per cycle, 16 words per block.

## Interface
Parameters:
- MAX_WORDS, default 20: maximum accepted message length in words; only used when MSG_PAD_OVF_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  padder accepts input word this cycle.
- in_data  in  32  message word.
- in_last  in  1  qualifies in_data as final word of the message.
- out_valid  out  1  output word valid (registered).
- out_ready  in  1  downstream accepts output word.
- out_data  out  32  padded block word (registered).
- out_first  out  1  out_data is word 0 of a block.
- out_last_blk  out  1  out_data is word 15 of the final block of a message.
- busy  out  1  a message is partially accepted or padding is in progress.
- ovf  out  1  sticky overflow flag; constant 0 unless MSG_PAD_OVF_EN is defined.

## Operation
- A single output register is loaded when `load = !out_valid || out_ready`.
- States:
  - DATA: `in_ready = load`. An accepted word goes to out_data and increments cnt (32-bit word count). If in_last is set on the accepted word, go to PAD.
  - PAD: emit `32'h80000000`, then go to ZERO. If the next position is 14, go directly to LENHI instead.
  - ZERO: emit 0 until the next position is 14, then go to LENHI.
  - LENHI: emit `{27'b0, cnt[31:27]}`.
  - LENLO: emit `{cnt[26:0], 5'b0}` with out_last_blk set. Then return to DATA with cnt = 0 and pos = 0.
- Transitions and counter increments occur only on cycles where load is true and a word is written into the output register.
- pos is a 4-bit block position that increments on every emitted word and wraps 15→0.
- out_first = (pos of emitted word == 0).
- If PAD lands at pos 14 or 15, ZERO fills the rest of the block and then pos 0..13 of an extra block.
- Length arithmetic is modulo 2^64 of bits, i.e. cnt×32. cnt wraps modulo 2^32.
- busy = (state != DATA) || (cnt != 0).
- Every message carries at least one word. Empty messages are not representable.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_first = 0, out_last_blk = 0, ovf = 0.
  - state = DATA, cnt = 0, pos = 0.
  - busy = 0, in_ready = 1 once reset_n is high.
- Latency: an input word accepted in cycle N is visible at out_data in cycle N+1.
- Throughput: 1 word/cycle with out_ready held high, including across padding and back-to-back messages.
- While padding (states other than DATA), in_ready = 0.
- Backpressure: while `out_valid && !out_ready`, out_data, out_first and out_last_blk are held stable and no state changes.
- Reset mid-message: the partial message is discarded, the output register is cleared, and the next accepted word starts a new message.
- Total output words = 16 × ceil((cnt + 3) / 16).

## Configuration
- MSG_PAD_OVF_EN defined:
  - A word accepted while cnt == MAX_WORDS is consumed but not forwarded, and cnt is not incremented.
  - ovf is set and stays sticky until the first word of the next message is accepted.
  - An accepted in_last still terminates the message normally. The length field reflects MAX_WORDS.
- MSG_PAD_OVF_EN undefined: no length limit, ovf tied to 0, MAX_WORDS unused.

## Test plan
- 20-word message, out_ready = 1 → 32 output words:
  - words 0..19 pass through unchanged;
  - word 20 = `80000000`, words 21..29 = 0, word 30 = 0, word 31 = `00000280`;
  - out_first on words 0 and 16; out_last_blk on word 31 only.
- 13-word message → 16 words: pos 13 = `80000000`, pos 14 = 0, pos 15 = `000001A0`.
- 14-word message → 32 words: pos 14 = `80000000`, pos 15 = 0, second block pos 0..14 = 0, pos 15 = `000001C0`.
- 20-word message under random out_ready (~50%) → output sequence identical to the first test, and out_data stable on every stalled cycle.
- Two back-to-back messages (5 words, then 3 words) with no idle cycles → 16 + 16 words, each with a correct length (`A0`, `60`); busy drops only after the second LENLO word is accepted. Then assert reset_n low mid-way through a third message → out_valid = 0 next cycle, and a subsequent 1-word message yields length `20`.
- With MSG_PAD_OVF_EN and MAX_WORDS = 20: 22-word message → words 21 and 22 dropped, ovf = 1, length word `00000280`; ovf clears when the next message's first word is accepted.
